// File: rtl/pat_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : pat_gen_multi
// Purpose  : Multi-mode test-pattern source (up-count, down-count, Galois
//            LFSR, walking-one) presented as a valid/ready stream, with a
//            wrap pulse and a saturating handshake counter.
// Options  : define PAT_GEN_ERR_INJ_EN to add inj_err_i, which flips bit 0
//            of exactly one word while the true sequence keeps running in a
//            shadow register.
// Revision : 1.0 - initial release
// ============================================================================
module pat_gen_multi #(
    parameter int unsigned        WIDTH_G     = 8,
    parameter int unsigned        CNT_W_G     = 16,
    parameter logic [WIDTH_G-1:0] LFSR_POLY_G = 8'hB8,
    parameter logic [WIDTH_G-1:0] SEED_G      = 8'h01
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               restart_i,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH_G-1:0] lim_i,
    input  logic               ready_i,
`ifdef PAT_GEN_ERR_INJ_EN
    input  logic               inj_err_i,
`endif
    output logic [WIDTH_G-1:0] data_o,
    output logic               valid_o,
    output logic               wrap_o,
    output logic [CNT_W_G-1:0] word_cnt_o,
    output logic               busy_o
);

    localparam logic [1:0] C_MODE_UP   = 2'd0;
    localparam logic [1:0] C_MODE_DOWN = 2'd1;
    localparam logic [1:0] C_MODE_LFSR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // A zero seed would lock the LFSR; a 1-bit word cannot rotate.
    generate
        if (SEED_G == '0) begin : g_seed_zero
            $error("pat_gen_multi: SEED_G must be nonzero");
        end
        if (WIDTH_G < 2) begin : g_width_small
            $error("pat_gen_multi: WIDTH_G must be at least 2");
        end
    endgenerate

    // Successor of d in the given mode; illegal states recover to a legal word.
    function automatic logic [WIDTH_G-1:0] next_val(input logic [1:0]         mode,
                                                     input logic [WIDTH_G-1:0] d,
                                                     input logic [WIDTH_G-1:0] lim);
        logic [WIDTH_G-1:0] nv;
        case (mode)
            C_MODE_UP:   nv = (d >= lim) ? '0 : d + 1'b1;
            C_MODE_DOWN: nv = ((d == '0) || (d > lim)) ? lim : d - 1'b1;
            C_MODE_LFSR: nv = (d == '0) ? SEED_G
                                        : ((d >> 1) ^ (d[0] ? LFSR_POLY_G : '0));
            default:     nv = ((d != '0) && ((d & (d - 1'b1)) == '0))
                                ? {d[WIDTH_G-2:0], d[WIDTH_G-1]}
                                : {{(WIDTH_G-1){1'b0}}, 1'b1};
        endcase
        return nv;
    endfunction

    // First word of a sequence; also the value that marks a wrap.
    function automatic logic [WIDTH_G-1:0] load_val(input logic [1:0]         mode,
                                                     input logic [WIDTH_G-1:0] lim);
        logic [WIDTH_G-1:0] lv;
        case (mode)
            C_MODE_UP:   lv = '0;
            C_MODE_DOWN: lv = lim;
            C_MODE_LFSR: lv = SEED_G;
            default:     lv = {{(WIDTH_G-1){1'b0}}, 1'b1};
        endcase
        return lv;
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH_G-1:0] data_q, data_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W_G-1:0] cnt_q, cnt_d;
    logic               pend_q, pend_d;

    logic               w_hs;
    logic [WIDTH_G-1:0] w_cur;
    logic [WIDTH_G-1:0] w_next;
    logic [WIDTH_G-1:0] w_out_next;

    assign w_hs   = (state_q == ST_RUN) & ready_i;
    assign w_next = next_val(mode_q, w_cur, lim_i);

`ifdef PAT_GEN_ERR_INJ_EN
    logic [WIDTH_G-1:0] shadow_q, shadow_d;

    // The sequence advances from the shadow so a corrupted word never propagates.
    assign w_cur      = shadow_q;
    assign w_out_next = w_next ^ {{(WIDTH_G-1){1'b0}}, inj_err_i};
`else
    assign w_cur      = data_q;
    assign w_out_next = w_next;
`endif

    // Next-state and datapath: LOAD initialises, RUN advances only on handshakes.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
`ifdef PAT_GEN_ERR_INJ_EN
        shadow_d = shadow_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mode_d  = mode_i;
                data_d  = load_val(mode_i, lim_i);
                cnt_d   = '0;
                pend_d  = 1'b0;
                state_d = ST_RUN;
`ifdef PAT_GEN_ERR_INJ_EN
                shadow_d = load_val(mode_i, lim_i);
`endif
            end
            ST_RUN: begin
                if (restart_i) begin
                    pend_d = 1'b1;
                end
                if (w_hs) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (!en_i) begin
                        state_d = ST_IDLE;
                    end else if (pend_q || restart_i) begin
                        state_d = ST_LOAD;
                    end else begin
                        data_d = w_out_next;
                        wrap_d = (w_next == load_val(mode_q, lim_i));
`ifdef PAT_GEN_ERR_INJ_EN
                        shadow_d = w_next;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= C_MODE_UP;
            data_q  <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PAT_GEN_ERR_INJ_EN
    // Shadow copy of the uncorrupted sequence value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign data_o     = data_q;
    assign valid_o    = (state_q == ST_RUN);
    assign wrap_o     = wrap_q;
    assign word_cnt_o = cnt_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pat_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pat_gen_multi
// Purpose  : Randomised scoreboard bench for pat_gen_multi. Expected words
//            come from closed-form sequence formulas per mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pat_gen_multi;

    localparam int         W    = 8;
    localparam int         CW   = 4;
    localparam int         CMAX = (1 << CW) - 1;
    localparam logic [7:0] POLY = 8'hB8;
    localparam logic [7:0] SEED = 8'h01;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          restart_i;
    logic [1:0]    mode_i;
    logic [W-1:0]  lim_i;
    logic          ready_i;
    logic [W-1:0]  data_o;
    logic          valid_o;
    logic          wrap_o;
    logic [CW-1:0] word_cnt_o;
    logic          busy_o;
`ifdef PAT_GEN_ERR_INJ_EN
    logic          inj_err_i = 1'b0;
`endif

    pat_gen_multi #(
        .WIDTH_G     (W),
        .CNT_W_G     (CW),
        .LFSR_POLY_G (POLY),
        .SEED_G      (SEED)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .restart_i  (restart_i),
        .mode_i     (mode_i),
        .lim_i      (lim_i),
        .ready_i    (ready_i),
`ifdef PAT_GEN_ERR_INJ_EN
        .inj_err_i  (inj_err_i),
`endif
        .data_o     (data_o),
        .valid_o    (valid_o),
        .wrap_o     (wrap_o),
        .word_cnt_o (word_cnt_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cnt;
        bit         wrap;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] lfsr_tab[255];
    bit         first_cyc = 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // Word i of a sequence started by LOAD, from the pattern rules directly.
    function automatic logic [7:0] ref_word(input int mode, input int lim, input int i);
        case (mode)
            0:       return 8'(i % (lim + 1));
            1:       return 8'(lim - (i % (lim + 1)));
            2:       return lfsr_tab[i % 255];
            default: return 8'(1 << (i % W));
        endcase
    endfunction

    // Queue n expected words of one sequence; wrap marks a return to word 0.
    function automatic void push_seg(input int mode, input int lim, input int n,
                                     input int cnt0, input bit wrap_first);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.data = ref_word(mode, lim, j);
            e.cnt  = sat(cnt0 + j);
            e.wrap = (j == 0) ? wrap_first : (e.data == ref_word(mode, lim, 0));
            sb_q.push_back(e);
        end
    endfunction

    // Monitor: every presented word is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_i) begin
            first_cyc = 1'b1;
        end else if (valid_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", valid_o, 0);
            end else begin
                chk("data", data_o, sb_q[0].data);
                chk("word_cnt", word_cnt_o, sb_q[0].cnt);
                chk("wrap", wrap_o, first_cyc ? sb_q[0].wrap : 1'b0);
                chk("busy_run", busy_o, 1);
                first_cyc = 1'b0;
                if (ready_i) begin
                    void'(sb_q.pop_front());
                    first_cyc = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        ready_i = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_cnt", word_cnt_o, 0);
        chk("rst_busy", busy_o, 0);
        sb_q.delete();
        en_i      = 1'b0;
        restart_i = 1'b0;
        @(posedge clk);
        #2;
        rst_i = 1'b0;
    endtask

    // One enable session of n handshakes, with optional restart, limit change,
    // mid-run reset or error injection at a given word index.
    task automatic run_session(input int mode, input int lim, input int n, input int rp,
                               input int rs_at, input int mode_b, input int lc_at,
                               input int lim2, input int rst_at, input int inj_at);
        int hs = 0;
        int cyc = 0;
        int cur_mode = mode;
        bit rs_done = 1'b0;
        bit seen_valid = 1'b0;
        int final_cnt;
        if (rs_at >= 0) begin
            push_seg(mode, lim, rs_at + 1, 0, 1'b0);
            push_seg(mode_b, lim, n - rs_at - 1, 0, 1'b0);
            final_cnt = sat(n - rs_at - 1);
        end else if (lc_at >= 0) begin
            push_seg(mode, lim, lc_at + 1, 0, 1'b0);
            push_seg(0, lim2, n - lc_at - 1, lc_at + 1, 1'b1);
            final_cnt = sat(n);
        end else begin
            push_seg(mode, lim, n, 0, 1'b0);
            final_cnt = sat(n);
        end
        if (inj_at >= 0) begin
`ifdef PAT_GEN_ERR_INJ_EN
            sb_q[inj_at + 1].data = sb_q[inj_at + 1].data ^ 8'h01;
`endif
        end
        @(posedge clk);
        #1;
        mode_i    = 2'(mode);
        lim_i     = 8'(lim);
        en_i      = 1'b1;
        ready_i   = 1'b0;
        restart_i = 1'b0;
        while (hs < n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > n * 30 + 60) begin
                chk("session_timeout", hs, n);
                do_reset();
                return;
            end
            restart_i = 1'b0;
`ifdef PAT_GEN_ERR_INJ_EN
            inj_err_i = 1'b0;
`endif
            if (!valid_o) begin
                mode_i  = 2'(cur_mode);
                ready_i = 1'($urandom_range(0, 1));
                if (!seen_valid && cyc == 1) chk("load_busy", busy_o, 1);
            end else begin
                if (!seen_valid) begin
                    chk("first_valid_latency", cyc, 2);
                    seen_valid = 1'b1;
                end
                if (hs == rst_at) begin
                    do_reset();
                    return;
                end
                mode_i  = 2'($urandom);
                ready_i = ($urandom_range(1, 100) <= rp);
                if (hs == rs_at && !rs_done) begin
                    restart_i = 1'b1;
                    rs_done   = 1'b1;
                end
                if (lc_at >= 0 && hs >= lc_at) lim_i = 8'(lim2);
                if (hs == inj_at) begin
                    ready_i = 1'b1;
`ifdef PAT_GEN_ERR_INJ_EN
                    inj_err_i = 1'b1;
`endif
                end
                if (hs == n - 1) en_i = 1'b0;
                if (ready_i) begin
                    if (rs_done && hs == rs_at) cur_mode = mode_b;
                    hs++;
                end
            end
        end
        @(posedge clk);
        #1;
        restart_i = 1'b0;
        ready_i   = 1'b0;
`ifdef PAT_GEN_ERR_INJ_EN
        inj_err_i = 1'b0;
`endif
        chk("end_valid", valid_o, 0);
        chk("end_busy", busy_o, 0);
        chk("end_cnt", word_cnt_o, final_cnt);
        chk("end_drained", sb_q.size(), 0);
    endtask

    initial begin
        logic [7:0] x;
        x = SEED;
        for (int k = 0; k < 255; k++) begin
            lfsr_tab[k] = x;
            x = (x >> 1) ^ (x[0] ? POLY : 8'h00);
        end

        rst_i = 1'b1; en_i = 1'b0; restart_i = 1'b0;
        mode_i = 2'd0; lim_i = 8'd0; ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_data", data_o, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_wrap", wrap_o, 0);
        chk("reset_cnt", word_cnt_o, 0);
        chk("reset_busy", busy_o, 0);

        //          mode lim  n   rp  rs  mB  lc  l2 rst inj
        run_session(0,   5,   7, 100, -1, 0, -1, 0, -1, -1);
        run_session(0,   5,  12,  40, -1, 0, -1, 0, -1, -1);
        run_session(0,   9,  20,  70, -1, 0,  9, 4, -1, -1);
        run_session(1,   3,  10,  60,  5, 1, -1, 0, -1, -1);
        run_session(2,   0, 260,  90, -1, 0, -1, 0, -1, -1);
        run_session(3,   0,  20,  60, -1, 0, -1, 0, -1, -1);
        run_session(0,   0,   5,  50, -1, 0, -1, 0, -1, -1);
        run_session(1,   0,   5,  50, -1, 0, -1, 0, -1, -1);
        run_session(1, 255,  10,  70,  4, 2, -1, 0, -1, -1);
        run_session(0, 255,   1,  50, -1, 0, -1, 0, -1, -1);
        run_session(0,  20,  15,  80, -1, 0, -1, 0,  6, -1);
        run_session(3,   0,   6,  70, -1, 0, -1, 0, -1, -1);
`ifdef PAT_GEN_ERR_INJ_EN
        run_session(0,   9,   8,  70, -1, 0, -1, 0, -1,  3);
`endif
        for (int s = 0; s < 14; s++) begin
            int m, l, n, r;
            m = int'($urandom_range(0, 3));
            l = ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, 12));
            n = int'($urandom_range(1, 30));
            r = (n >= 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 2)) : -1;
            run_session(m, l, n, int'($urandom_range(30, 100)), r,
                        int'($urandom_range(0, 3)), -1, 0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
